// File: rtl/vslc_btn_pkg.sv
// Purpose: shared state encoding and default constants for the button-input block.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package vslc_btn_pkg;

   // Per-channel debounce FSM. The *_WAIT states hold the previously accepted level
   // while a candidate level change is being qualified.
   typedef enum logic [1:0] {
      ST_REL        = 2'd0,  // stable released
      ST_PRESS_WAIT = 2'd1,  // released, qualifying a press
      ST_PRS        = 2'd2,  // stable pressed
      ST_REL_WAIT   = 2'd3   // pressed, qualifying a release
   } btn_state_e;

   localparam int         DEF_N_BTN           = 4;
   localparam int         DEF_DEBOUNCE_CYCLES = 65536;
   localparam logic [3:0] DEF_INVERT_MASK     = 4'b0001;  // bit 0 is the active-low BTN_N pin

   // The accepted level stays pressed until a release has been fully qualified.
   function automatic logic state_is_pressed(btn_state_e s);
      return (s == ST_PRS) || (s == ST_REL_WAIT);
   endfunction

endpackage

// File: rtl/tt_um_jimktrains_vslc_btn_in_if.sv
// Purpose: bundle of raw button pins and debounced level/edge outputs.
// Latency: n/a (wiring only).
// Backpressure: none; outputs are levels and single-cycle pulses with no ready.
// Ports: btn_raw (pins into the block), btn_level/btn_rise/btn_fall/any_change (results out).
interface tt_um_jimktrains_vslc_btn_in_if #(
   parameter int N_BTN = 4
);
   logic [N_BTN-1:0] btn_raw;
   logic [N_BTN-1:0] btn_level;
   logic [N_BTN-1:0] btn_rise;
   logic [N_BTN-1:0] btn_fall;
   logic             any_change;

   // master: the pin/consumer side; slave: the debouncer.
   modport master (output btn_raw, input btn_level, input btn_rise, input btn_fall, input any_change);
   modport slave  (input btn_raw, output btn_level, output btn_rise, output btn_fall, output any_change);
endinterface

// File: rtl/vslc_btn_debounce_ch.sv
// Purpose: one button channel: 2-flop synchronizer, 4-state debounce FSM, saturating counter.
// Latency: 2 + DEBOUNCE_CYCLES clocks from a stable raw edge to the level change.
// Backpressure: none; rise/fall are single-cycle pulses that cannot be stalled.
// Ports: clk, rst_n (async active-low), sample_raw (polarity-corrected pin),
//        level (1 = pressed), rise/fall (one-cycle pulses aligned with the level change).
module vslc_btn_debounce_ch
   import vslc_btn_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sample_raw,
   output logic level,
   output logic rise,
   output logic fall
);

   localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   btn_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] cnt_inc;
   logic             rise_q, rise_d;
   logic             fall_q, fall_d;

   always_comb begin
      sync1_d = sample_raw;
      sync2_d = sync1_q;
      state_d = state_q;
      cnt_d   = cnt_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;

      // Saturate rather than wrap so a stuck count can never alias back to zero.
      cnt_inc = (cnt_q == CNT_LAST) ? cnt_q : cnt_q + CNT_W'(1);

      // The counter restarts from zero on every state change.
      unique case (state_q)
         ST_REL: begin
            if (sync2_q) begin
               state_d = ST_PRESS_WAIT;
               cnt_d   = '0;
            end
         end
         ST_PRESS_WAIT: begin
            if (!sync2_q) begin
               state_d = ST_REL;          // glitch: drop the candidate press silently
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_PRS;
               cnt_d   = '0;
               rise_d  = 1'b1;
            end else begin
               cnt_d   = cnt_inc;
            end
         end
         ST_PRS: begin
            if (!sync2_q) begin
               state_d = ST_REL_WAIT;
               cnt_d   = '0;
            end
         end
         ST_REL_WAIT: begin
            if (sync2_q) begin
               state_d = ST_PRS;          // glitch: drop the candidate release silently
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_REL;
               cnt_d   = '0;
               fall_d  = 1'b1;
            end else begin
               cnt_d   = cnt_inc;
            end
         end
         default: begin
            state_d = ST_REL;
            cnt_d   = '0;
         end
      endcase
   end

   // Synchronizer resets to the released value so an idle pin never looks pressed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         state_q <= ST_REL;
         cnt_q   <= '0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   // rise_q/fall_q load on the same edge that moves state into/out of the pressed
   // pair, so each pulse coincides with the level change.
   assign level = state_is_pressed(state_q);
   assign rise  = rise_q;
   assign fall  = fall_q;

endmodule

// File: rtl/tt_um_jimktrains_vslc_btn_in.sv
// Purpose: N_BTN-channel button debouncer with per-channel pin polarity and edge pulses.
// Latency: 2 + DEBOUNCE_CYCLES clocks from a stable raw edge to btn_level/btn_rise/btn_fall.
// Backpressure: none; pulses are single-cycle and any_change is their combined OR.
// Ports: clk, rst_n (async active-low), btn_if (slave: btn_raw in; btn_level,
//        btn_rise, btn_fall, any_change out).
module tt_um_jimktrains_vslc_btn_in
   import vslc_btn_pkg::*;
#(
   parameter int               N_BTN           = DEF_N_BTN,
   parameter int               DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter logic [N_BTN-1:0] INVERT_MASK     = DEF_INVERT_MASK
) (
   input  logic                           clk,
   input  logic                           rst_n,
   tt_um_jimktrains_vslc_btn_in_if.slave  btn_if
);

   logic [N_BTN-1:0] raw_pol;
   logic [N_BTN-1:0] level;
   logic [N_BTN-1:0] rise;
   logic [N_BTN-1:0] fall;

   // After this XOR every channel reads 1 = pressed regardless of pin polarity.
   assign raw_pol = btn_if.btn_raw ^ INVERT_MASK;

   for (genvar i = 0; i < N_BTN; i++) begin : g_ch
      vslc_btn_debounce_ch #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_ch (
         .clk        (clk),
         .rst_n      (rst_n),
         .sample_raw (raw_pol[i]),
         .level      (level[i]),
         .rise       (rise[i]),
         .fall       (fall[i])
      );
   end

   assign btn_if.btn_level  = level;
   assign btn_if.btn_rise   = rise;
   assign btn_if.btn_fall   = fall;
   assign btn_if.any_change = |(rise | fall);

endmodule

// File: tb/tb_tt_um_jimktrains_vslc_btn_in.sv
module tb_tt_um_jimktrains_vslc_btn_in;
   import vslc_btn_pkg::*;

   logic clk;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;

   tt_um_jimktrains_vslc_btn_in_if #(.N_BTN(4)) btn_if ();

   tt_um_jimktrains_vslc_btn_in #(
      .N_BTN           (4),
      .DEBOUNCE_CYCLES (8),
      .INVERT_MASK     (4'b0001)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .btn_if (btn_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge; return at the following falling edge (drive/sample point).
   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic check_outputs(input string tag, input logic [3:0] lvl, input logic [3:0] r,
                                input logic [3:0] f);
      check($sformatf("%s.level", tag), {4'd0, btn_if.btn_level}, {4'd0, lvl});
      check($sformatf("%s.rise", tag),  {4'd0, btn_if.btn_rise},  {4'd0, r});
      check($sformatf("%s.fall", tag),  {4'd0, btn_if.btn_fall},  {4'd0, f});
      check($sformatf("%s.any", tag),   {7'd0, btn_if.any_change}, {7'd0, |(r | f)});
   endtask

   // Run n edges after the last input change. Edge number 'at' (1-based, 0 = never)
   // is where the level moves from lvl_before to lvl_after and the pulses appear.
   task automatic run_expect(input string tag, input int n, input logic [3:0] lvl_before,
                             input logic [3:0] lvl_after, input logic [3:0] r_mask,
                             input logic [3:0] f_mask, input int at);
      logic [3:0] lvl;
      for (int k = 1; k <= n; k++) begin
         cyc();
         lvl = (at != 0 && k >= at) ? lvl_after : lvl_before;
         check_outputs($sformatf("%s@%0d", tag, k), lvl,
                       (k == at) ? r_mask : 4'b0000,
                       (k == at) ? f_mask : 4'b0000);
      end
   endtask

   // With D=8 the first edge that samples a new raw value is edge 1, and the
   // accepted change shows up 2+D edges later, i.e. on edge 11.
   localparam int ACC = 11;

   initial begin
      rst_n          = 1'b0;
      btn_if.btn_raw = 4'b0001;            // everything released; bit 0 is active-low

      // Reset state, with the clock running.
      for (int k = 0; k < 3; k++) begin
         cyc();
         check_outputs($sformatf("reset%0d", k), 4'b0000, 4'b0000, 4'b0000);
      end

      // Idle pins held through reset release: no level change, no pulse.
      rst_n = 1'b1;
      run_expect("idle", 50, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0);

      // Single press on channel 1.
      btn_if.btn_raw = 4'b0011;
      run_expect("press1", 14, 4'b0000, 4'b0010, 4'b0010, 4'b0000, ACC);

      // 5-cycle glitch on channel 2 is rejected.
      btn_if.btn_raw = 4'b0111;
      run_expect("glitch_hi", 5, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 0);
      btn_if.btn_raw = 4'b0011;
      run_expect("glitch_lo", 15, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 0);

      // Active-low channel 0: pin low is a press, pin high a release.
      btn_if.btn_raw = 4'b0010;
      run_expect("btnn_press", 14, 4'b0010, 4'b0011, 4'b0001, 4'b0000, ACC);
      btn_if.btn_raw = 4'b0011;
      run_expect("btnn_rel", 14, 4'b0011, 4'b0010, 4'b0000, 4'b0001, ACC);

      // Release channel 1.
      btn_if.btn_raw = 4'b0001;
      run_expect("rel1", 14, 4'b0010, 4'b0000, 4'b0000, 4'b0010, ACC);

      // Channels 3 and 1 together: one combined pulse.
      btn_if.btn_raw = 4'b1011;
      run_expect("dual_press", 14, 4'b0000, 4'b1010, 4'b1010, 4'b0000, ACC);

      // Channel 2 toggling with a 4-cycle period never gets through.
      for (int t = 0; t < 10; t++) begin
         btn_if.btn_raw = 4'b1111;
         run_expect("toggle_hi", 2, 4'b1010, 4'b1010, 4'b0000, 4'b0000, 0);
         btn_if.btn_raw = 4'b1011;
         run_expect("toggle_lo", 2, 4'b1010, 4'b1010, 4'b0000, 4'b0000, 0);
      end
      run_expect("toggle_settle", 12, 4'b1010, 4'b1010, 4'b0000, 4'b0000, 0);

      // Release both simultaneously.
      btn_if.btn_raw = 4'b0001;
      run_expect("dual_rel", 14, 4'b1010, 4'b0000, 4'b0000, 4'b1010, ACC);

      // Reset 6 edges into a press debounce; the held press needs the full time again.
      btn_if.btn_raw = 4'b0011;
      run_expect("pre_rst", 6, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0);
      rst_n = 1'b0;
      for (int k = 0; k < 3; k++) begin
         cyc();
         check_outputs($sformatf("mid_rst%0d", k), 4'b0000, 4'b0000, 4'b0000);
      end
      rst_n = 1'b1;
      run_expect("post_rst", 14, 4'b0000, 4'b0010, 4'b0010, 4'b0000, ACC);

      // Reset while pressed clears the level at once, without waiting for a clock edge.
      rst_n = 1'b0;
      #1;
      check_outputs("async_rst", 4'b0000, 4'b0000, 4'b0000);
      cyc();
      cyc();
      rst_n = 1'b1;
      run_expect("held_after_rst", 14, 4'b0000, 4'b0010, 4'b0010, 4'b0000, ACC);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
